// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures line/frame timing, active pixel count and checksum, declares lock.
// Optional define VGA_TIMING_MONITOR_CLEAR_EN enables a software clear of error_count/frame_count via address 0.
module vga_timing_monitor #(
  parameter int unsigned EXP_HTOTAL = 800,
  parameter int unsigned EXP_VTOTAL = 525,
  parameter int unsigned EXP_ACTIVE = 307200,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        locked,
  output logic        frame_pulse
);

  typedef enum logic [1:0] {HUNT = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic        clk_q, clk_qq, hs_q, hs_qq, vs_q, vs_qq, blank_q;
  logic [23:0] rgb_q;
  logic        strobe, hs_fall, hs_rise, vs_fall, act_step;

  logic [15:0] pix_cnt, line_len, hs_cnt, hs_width, line_cnt, frame_lines;
  logic [15:0] line_len_n, lines_n;
  logic [31:0] active_cnt, active_lat, checksum, checksum_lat;
  logic [31:0] frame_count;
  logic [15:0] error_count;
  logic [IW-1:0] idle_cnt;
  logic        timeout, frame_match, err_inc, fc_inc, clear_req;
  state_t      state, state_n;
  logic [31:0] rd_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_q   <= 1'b0;
      clk_qq  <= 1'b0;
      hs_q    <= 1'b0;
      hs_qq   <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      clk_q   <= vga_clk;
      clk_qq  <= clk_q;
      hs_q    <= vga_hs;
      hs_qq   <= hs_q;
      vs_q    <= vga_vs;
      vs_qq   <= vs_q;
      blank_q <= vga_blank_n;
      rgb_q   <= {vga_r, vga_g, vga_b};
    end
  end

  assign strobe   = clk_q & ~clk_qq;
  assign hs_fall  = hs_qq & ~hs_q;
  assign hs_rise  = ~hs_qq & hs_q;
  assign vs_fall  = vs_qq & ~vs_q;
  assign act_step = strobe & blank_q;

  // Lock decision uses the values that this vs_fall is about to latch.
  assign line_len_n  = hs_fall ? pix_cnt : line_len;
  assign lines_n     = hs_fall ? sat_inc16(line_cnt) : line_cnt;
  assign frame_match = (line_len_n == 16'(EXP_HTOTAL)) &&
                       (lines_n == 16'(EXP_VTOTAL)) &&
                       (active_cnt == 32'(EXP_ACTIVE));

  assign timeout = ~strobe && (idle_cnt == IW'(TIMEOUT - 1));

`ifdef VGA_TIMING_MONITOR_CLEAR_EN
  assign clear_req = chipselect && write && (address == 3'd0) && writedata[0];
  logic unused_wr;
  assign unused_wr = ^writedata[31:1];
`else
  assign clear_req = 1'b0;
  logic unused_wr;
  assign unused_wr = ^{write, writedata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt      <= '0;
      line_len     <= '0;
      hs_cnt       <= '0;
      hs_width     <= '0;
      line_cnt     <= '0;
      frame_lines  <= '0;
      active_cnt   <= '0;
      active_lat   <= '0;
      checksum     <= '0;
      checksum_lat <= '0;
      idle_cnt     <= '0;
      frame_pulse  <= 1'b0;
    end else begin
      if (hs_fall) begin
        line_len <= pix_cnt;
        pix_cnt  <= {15'b0, strobe};
      end else if (strobe) begin
        pix_cnt <= sat_inc16(pix_cnt);
      end

      if (hs_fall)
        hs_cnt <= {15'b0, strobe};
      else if (strobe && !hs_q)
        hs_cnt <= sat_inc16(hs_cnt);
      if (hs_rise)
        hs_width <= hs_cnt;

      if (vs_fall) begin
        frame_lines  <= lines_n;
        line_cnt     <= '0;
        active_lat   <= active_cnt;
        active_cnt   <= {31'b0, act_step};
        checksum_lat <= checksum;
        checksum     <= act_step ? {8'b0, rgb_q} : '0;
      end else begin
        line_cnt <= lines_n;
        if (act_step) begin
          if (active_cnt != '1)
            active_cnt <= active_cnt + 32'd1;
          checksum <= checksum + {8'b0, rgb_q};
        end
      end

      if (strobe || timeout)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      frame_pulse <= vs_fall;
    end
  end

  always_comb begin
    state_n = state;
    err_inc = 1'b0;
    fc_inc  = vs_fall && (state != HUNT);
    if (timeout) begin
      state_n = HUNT;
    end else if (vs_fall) begin
      case (state)
        HUNT:    state_n = MEASURE;
        MEASURE: if (frame_match) state_n = LOCKED;
        LOCKED:  if (!frame_match) begin
                   state_n = MEASURE;
                   err_inc = 1'b1;
                 end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      locked      <= 1'b0;
      error_count <= '0;
      frame_count <= '0;
    end else begin
      state  <= state_n;
      locked <= (state_n == LOCKED);
      if (clear_req)
        error_count <= '0;
      else if (err_inc && error_count != '1)
        error_count <= error_count + 16'd1;
      if (clear_req)
        frame_count <= '0;
      else if (fc_inc)
        frame_count <= frame_count + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = {error_count, 13'b0, locked, state};
      3'd1: rd_mux = {line_len, hs_width};
      3'd2: rd_mux = {16'b0, frame_lines};
      3'd3: rd_mux = active_lat;
      3'd4: rd_mux = checksum_lat;
      3'd5: rd_mux = frame_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else if (chipselect && read)
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 20x8 raster (10x5 active) so frames stay short.
module tb_vga_timing_monitor;

  localparam int H_TOT = 20;
  localparam int HSW   = 3;
  localparam int HA0   = 5;
  localparam int HACT  = 10;
  localparam int V_TOT = 8;
  localparam int VA0   = 2;
  localparam int VACT  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        chipselect, read, write;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic        locked, frame_pulse;

  logic        run   = 1'b0;
  logic        extra = 1'b0;
  logic [23:0] colour = 24'h000080;

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing_monitor #(
    .EXP_HTOTAL(H_TOT),
    .EXP_VTOTAL(V_TOT),
    .EXP_ACTIVE(HACT * VACT),
    .TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata),
    .readdata(readdata), .locked(locked), .frame_pulse(frame_pulse)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic put_pixel(input logic hs, input logic vs, input logic bl);
    while (!run) begin
      vga_clk = 1'b0;
      @(posedge clk); #1;
    end
    vga_clk     = 1'b0;
    vga_hs      = hs;
    vga_vs      = vs;
    vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = colour;
    @(posedge clk); #1;
    vga_clk = 1'b1;
    @(posedge clk); #1;
  endtask

  // Raster source: hs low for the first HSW pixels of each line, vs low on line 0.
  initial begin
    vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    forever begin
      for (int y = 0; y < V_TOT; y++) begin
        for (int x = 0; x < H_TOT; x++) begin
          put_pixel(x >= HSW, y >= 1,
                    (x >= HA0) && (x < HA0 + HACT) && (y >= VA0) && (y < VA0 + VACT));
          if (extra && y == V_TOT - 1 && x == H_TOT - 1) begin
            extra = 1'b0;
            put_pixel(1'b1, 1'b1, 1'b0);
          end
        end
      end
    end
  end

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      seen = frame_pulse;
    end
    check("frame_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] wd);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, prev, fc0;
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_pulse", {31'b0, frame_pulse}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    read_reg(3'd0, d); check("rst_reg0", d, 32'd0);

    // Acquire lock: first vs_fall leaves HUNT, second completes a measured frame.
    run = 1'b1;
    wait_frame(); read_reg(3'd0, d); check("hunt_to_measure", d, 32'h0000_0001);
    wait_frame();
    check("locked_out", {31'b0, locked}, 32'd1);
    read_reg(3'd0, d); check("reg0_locked", d, 32'h0000_0006);
    read_reg(3'd1, d); check("reg1_len_hsw", d, {16'd20, 16'd3});
    read_reg(3'd2, d); check("reg2_lines", d, 32'd8);
    read_reg(3'd3, d); check("reg3_active", d, 32'd50);
    read_reg(3'd4, d); check("reg4_checksum", d, 32'd6400);
    read_reg(3'd5, d); check("reg5_fcount", d, 32'd1);

    prev = d;
    for (int k = 0; k < 3; k++) begin
      wait_frame();
      check("rdata_hold", readdata, prev);
      read_reg(3'd5, d);
      check("fcount_step", d, prev + 32'd1);
      prev = d;
    end

    colour = 24'hFFFFFF;
    wait_frame();
    colour = 24'h000080;
    read_reg(3'd4, d); check("checksum_white", d, 32'd838860750);
    read_reg(3'd0, d); check("still_locked", d, 32'h0000_0006);

    // One extra strobe on the final line of a frame.
    extra = 1'b1;
    wait_frame();
    read_reg(3'd1, d); check("extra_len", {16'b0, d[31:16]}, 32'd21);
    read_reg(3'd0, d); check("extra_reg0", d, 32'h0001_0001);
    check("extra_unlocked", {31'b0, locked}, 32'd0);
    wait_frame();
    read_reg(3'd0, d); check("relock_reg0", d, 32'h0001_0006);

    // Freeze the pixel clock.
    run = 1'b0;
    repeat (900) @(posedge clk);
    #1 check("freeze_900", {31'b0, locked}, 32'd1);
    repeat (200) @(posedge clk);
    #1 check("freeze_timeout", {31'b0, locked}, 32'd0);
    read_reg(3'd0, d); check("timeout_reg0", d, 32'h0001_0000);
    run = 1'b1;
    wait_frame(); read_reg(3'd0, d); check("resume_measure", d, 32'h0001_0001);
    wait_frame(); read_reg(3'd0, d); check("resume_locked", d, 32'h0001_0006);

    read_reg(3'd5, fc0);
    write_reg(3'd0, 32'd1);
`ifdef VGA_TIMING_MONITOR_CLEAR_EN
    read_reg(3'd0, d); check("clear_reg0", d, 32'h0000_0006);
    read_reg(3'd5, d); check("clear_fcount", d, 32'd0);
`else
    read_reg(3'd0, d); check("noclear_reg0", d, 32'h0001_0006);
    read_reg(3'd5, d); check("noclear_fcount", d, fc0);
`endif

    // Reset in the middle of a frame.
    wait_frame();
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_locked", {31'b0, locked}, 32'd0);
    check("mid_rst_rdata", readdata, 32'd0);
    check("mid_rst_pulse", {31'b0, frame_pulse}, 32'd0);
    read_reg(3'd0, d); check("mid_rst_reg0", d, 32'd0);
    read_reg(3'd5, d); check("mid_rst_fcount", d, 32'd0);
    wait_frame(); read_reg(3'd0, d); check("post_rst_measure", d, 32'h0000_0001);
    wait_frame();
    check("post_rst_locked", {31'b0, locked}, 32'd1);
    read_reg(3'd0, d); check("post_rst_reg0", d, 32'h0000_0006);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
